// File: rtl/power_level_sequencer.sv
// Ramps the power-stage level one LSB per STEP_CYC clocks toward the target chosen by a one-hot
// setting; a multi-hot setting latches a fault and ramps the level back to zero.
module power_level_sequencer #(
   parameter int W         = 8,
   parameter int TRAIN_LVL = 16,
   parameter int DUEL_LVL  = 64,
   parameter int BULK_LVL  = 255,
   parameter int STEP_CYC  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   powSet,
   input  logic         fault_clr,
   output logic [W-1:0] level,
   output logic [1:0]   mode,
   output logic         ramping,
   output logic         at_target,
   output logic         fault
);
   localparam int CW = $clog2(STEP_CYC);

   typedef enum logic [1:0] {OFF, RAMP, HOLD, FLT} state_t;

   state_t         state_q, state_d;
   logic [2:0]     pow_q;
   logic [W-1:0]   tgt_q, tgt_d, level_d;
   logic [CW-1:0]  step_q, step_d;
   logic [1:0]     mode_d;
   logic           ramping_d, at_target_d, fault_d;

   logic           dec_vld;
   logic [W-1:0]   dec_tgt;
   logic [1:0]     dec_mode;
   logic           step_now;
   logic [W-1:0]   step_lvl;

   always_comb begin
      dec_vld  = 1'b1;
      dec_tgt  = '0;
      dec_mode = 2'd0;
      case (pow_q)
         3'b000: ;
         3'b001: begin dec_tgt = W'(TRAIN_LVL); dec_mode = 2'd1; end
         3'b010: begin dec_tgt = W'(DUEL_LVL);  dec_mode = 2'd2; end
         3'b100: begin dec_tgt = W'(BULK_LVL);  dec_mode = 2'd3; end
         default: dec_vld = 1'b0;
      endcase
   end

   // In FAULT tgt_q is held at zero, so the same step arithmetic walks the level down.
   assign step_now = (step_q == CW'(STEP_CYC - 1));
   assign step_lvl = (level < tgt_q) ? level + W'(1) : level - W'(1);

   always_comb begin
      state_d     = state_q;
      level_d     = level;
      tgt_d       = tgt_q;
      step_d      = step_q;
      mode_d      = mode;
      ramping_d   = ramping;
      at_target_d = at_target;
      fault_d     = fault;

      if (!dec_vld && state_q != FLT) begin
         state_d     = FLT;
         fault_d     = 1'b1;
         mode_d      = 2'd0;
         at_target_d = 1'b0;
         tgt_d       = '0;
         step_d      = '0;
         ramping_d   = (level != '0);
      end else if (state_q == FLT) begin
         if (dec_vld && fault_clr && level == '0) begin
            state_d = OFF;
            fault_d = 1'b0;
            step_d  = '0;
         end else if (level != '0) begin
            if (step_now) begin
               step_d  = '0;
               level_d = step_lvl;
               if (step_lvl == '0)
                  ramping_d = 1'b0;
            end else begin
               step_d = step_q + CW'(1);
            end
         end
      end else begin
         case (state_q)
            OFF: begin
               if (dec_tgt != '0) begin
                  state_d   = RAMP;
                  tgt_d     = dec_tgt;
                  mode_d    = dec_mode;
                  step_d    = '0;
                  ramping_d = 1'b1;
               end
            end
            RAMP: begin
               if (dec_tgt != tgt_q) begin
                  tgt_d  = dec_tgt;
                  mode_d = dec_mode;
                  step_d = '0;
                  // A retarget that lands exactly on the current level settles at once.
                  if (dec_tgt == level) begin
                     state_d     = (dec_tgt != '0) ? HOLD : OFF;
                     ramping_d   = 1'b0;
                     at_target_d = (dec_tgt != '0);
                  end
               end else if (step_now) begin
                  step_d  = '0;
                  level_d = step_lvl;
                  if (step_lvl == tgt_q) begin
                     state_d     = (tgt_q != '0) ? HOLD : OFF;
                     ramping_d   = 1'b0;
                     at_target_d = (tgt_q != '0);
                  end
               end else begin
                  step_d = step_q + CW'(1);
               end
            end
            HOLD: begin
               if (dec_tgt != tgt_q) begin
                  state_d     = RAMP;
                  tgt_d       = dec_tgt;
                  mode_d      = dec_mode;
                  step_d      = '0;
                  ramping_d   = 1'b1;
                  at_target_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= OFF;
         pow_q     <= '0;
         tgt_q     <= '0;
         step_q    <= '0;
         level     <= '0;
         mode      <= 2'd0;
         ramping   <= 1'b0;
         at_target <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pow_q     <= powSet;
         tgt_q     <= tgt_d;
         step_q    <= step_d;
         level     <= level_d;
         mode      <= mode_d;
         ramping   <= ramping_d;
         at_target <= at_target_d;
         fault     <= fault_d;
      end
   end
endmodule

// File: tb/tb_power_level_sequencer.sv
// Directed scenarios for power_level_sequencer, checked every cycle against a behavioural model.
module tb_power_level_sequencer;
   localparam int STEP = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] powSet = 3'b000;
   logic       fault_clr = 1'b0;
   logic [7:0] level;
   logic [1:0] mode;
   logic       ramping, at_target, fault;

   int n_checks = 0;
   int n_err    = 0;

   power_level_sequencer dut (
      .clk(clk), .rst(rst), .powSet(powSet), .fault_clr(fault_clr),
      .level(level), .mode(mode), .ramping(ramping), .at_target(at_target), .fault(fault)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit code_ok(input logic [2:0] c);
      return (c == 3'b000) || (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
   endfunction

   function automatic int tgt_of(input logic [2:0] c);
      case (c)
         3'b001:  return 16;
         3'b010:  return 64;
         3'b100:  return 255;
         default: return 0;
      endcase
   endfunction

   function automatic int mode_of(input logic [2:0] c);
      case (c)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 3;
         default: return 0;
      endcase
   endfunction

   // Model: level, target, fault flag and a countdown of clocks to the next 1-LSB move.
   logic [2:0] m_pq = 3'b000;
   int  m_lvl = 0, m_tgt = 0, m_mode = 0, m_cnt = STEP;
   bit  m_fault = 1'b0;

   task automatic m_walk();
      if (m_lvl != m_tgt) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_lvl += (m_tgt > m_lvl) ? 1 : -1;
            m_cnt  = STEP;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_pq = 3'b000; m_lvl = 0; m_tgt = 0; m_mode = 0; m_cnt = STEP; m_fault = 1'b0;
      end else begin
         if (!code_ok(m_pq)) begin
            if (!m_fault) begin
               m_fault = 1'b1; m_tgt = 0; m_mode = 0; m_cnt = STEP;
            end else begin
               m_walk();
            end
         end else if (m_fault) begin
            if (m_lvl == 0 && fault_clr) m_fault = 1'b0;
            else m_walk();
         end else if (tgt_of(m_pq) != m_tgt) begin
            m_tgt = tgt_of(m_pq); m_mode = mode_of(m_pq); m_cnt = STEP;
         end else begin
            m_walk();
         end
         m_pq = powSet;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("model level", int'(level), m_lvl);
      chk("model mode", int'(mode), m_fault ? 0 : m_mode);
      chk("model ramping", int'(ramping), m_fault ? int'(m_lvl != 0) : int'(m_lvl != m_tgt));
      chk("model at_target", int'(at_target), int'(!m_fault && m_tgt != 0 && m_lvl == m_tgt));
      chk("model fault", int'(fault), int'(m_fault));
   end

   task automatic wait_level(input string name, input int lvl, input int budget);
      int n = 0;
      while (int'(level) != lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, " reached"}, int'(level), lvl);
   endtask

   // Drives a code at a negedge and checks the first step lands 5 edges after capture.
   task automatic first_step(input string name, input logic [2:0] code);
      powSet = code;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1 chk({name, " pre-step"}, int'(level), 0);
      @(posedge clk);
      #1 chk({name, " first step"}, int'(level), 1);
      chk({name, " ramping"}, int'(ramping), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exhausted, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset level", int'(level), 0);
      chk("reset mode", int'(mode), 0);
      chk("reset flags", {ramping, at_target, fault}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: training ramp 0 -> 16
      first_step("t1", 3'b001);
      chk("t1 mode", int'(mode), 1);
      repeat (59) @(posedge clk);
      #1 chk("t1 level 64 after", int'(level), 15);
      chk("t1 not at target", int'(at_target), 0);
      @(posedge clk);
      #1 chk("t1 level 65 after", int'(level), 16);
      chk("t1 at_target", int'(at_target), 1);
      chk("t1 ramping done", int'(ramping), 0);
      @(negedge clk);

      // 2: HOLD 16 -> bulkhead 255, no wrap
      powSet = 3'b100;
      repeat (2) @(negedge clk);
      chk("t2 mode", int'(mode), 3);
      chk("t2 ramping", int'(ramping), 1);
      wait_level("t2 255", 255, 1200);
      chk("t2 at_target", int'(at_target), 1);
      repeat (40) @(negedge clk);
      chk("t2 no wrap", int'(level), 255);

      // 3: reverse mid-ramp toward 64 at level 30
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      powSet = 3'b010;
      wait_level("t3 30", 30, 300);
      powSet = 3'b001;
      repeat (2) @(posedge clk);
      #1 chk("t3 mode", int'(mode), 1);
      chk("t3 no jump", int'(level), 30);
      @(negedge clk);
      wait_level("t3 16", 16, 200);
      chk("t3 hold", int'(at_target), 1);

      // 4: fault from HOLD at 64, then clear with 000
      powSet = 3'b010;
      wait_level("t4 64", 64, 400);
      powSet = 3'b011;
      repeat (2) @(negedge clk);
      chk("t4 fault", int'(fault), 1);
      chk("t4 mode", int'(mode), 0);
      chk("t4 level", int'(level), 64);
      wait_level("t4 zero", 0, 400);
      repeat (10) @(negedge clk);
      chk("t4 fault held", int'(fault), 1);
      chk("t4 stays zero", int'(level), 0);
      powSet = 3'b000;
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("t4 cleared", int'(fault), 0);

      // 5: clear ignored under invalid code, honoured under valid one
      powSet = 3'b110;
      repeat (2) @(negedge clk);
      chk("t5 fault at zero", int'(fault), 1);
      chk("t5 no ramp", int'(ramping), 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("t5 clr under invalid", int'(fault), 1);
      powSet = 3'b010;
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("t5 cleared", int'(fault), 0);
      chk("t5 off mode", int'(mode), 0);
      @(negedge clk);
      chk("t5 duel mode", int'(mode), 2);
      wait_level("t5 64", 64, 400);

      // 6: async reset mid-ramp at 40, then restart
      powSet = 3'b000;
      wait_level("t6 40", 40, 200);
      #2 rst = 1'b1;
      #1 chk("t6 async level", int'(level), 0);
      chk("t6 async flags", {mode, ramping, at_target, fault}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      first_step("t6 restart", 3'b001);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
